// File: rtl/vmicro16_uart_rx_apb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vmicro16_uart_rx_apb_pkg : register map, STATUS bits, FSM encodings, flags
// Revision 1.0
// ---------------------------------------------------------------------------
package vmicro16_uart_rx_apb_pkg;

  localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

  localparam logic UART_REG_DATA   = 1'b0;
  localparam logic UART_REG_STATUS = 1'b1;

  localparam int UART_STAT_NOT_EMPTY = 0;
  localparam int UART_STAT_FERR      = 1;
  localparam int UART_STAT_OVR       = 2;
  localparam int UART_STAT_PERR      = 3;
  localparam int UART_STAT_COUNT_LSB = 8;

  localparam logic [2:0] UART_ST_IDLE   = 3'd0;
  localparam logic [2:0] UART_ST_START  = 3'd1;
  localparam logic [2:0] UART_ST_DATA   = 3'd2;
  localparam logic [2:0] UART_ST_PARITY = 3'd3;
  localparam logic [2:0] UART_ST_STOP   = 3'd4;

  typedef struct packed {
    logic perr;
    logic ovr;
    logic ferr;
  } uart_flags_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vmicro16_uart_rx_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vmicro16_uart_rx_core : rx synchroniser, baud counter and frame FSM
// Optional even parity: VMICRO16_UART_RX_PARITY_EN.   Revision 1.0
// ---------------------------------------------------------------------------
module vmicro16_uart_rx_core
  import vmicro16_uart_rx_apb_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       ferr_o,
  output logic       perr_o
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_TICK = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_TICK = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    sync_q;
  logic          rx_prev_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          rx_s, tick_full, tick_half, perr_hold;

  assign rx_s      = sync_q[1];
  assign tick_full = (cnt_q == FULL_TICK);
  assign tick_half = (cnt_q == HALF_TICK);
  assign byte_o    = shift_q;

`ifdef VMICRO16_UART_RX_PARITY_EN
  logic perr_flag_q, perr_flag_d;
  assign perr_hold = perr_flag_q;
`else
  assign perr_hold = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_o = 1'b0;
    ferr_o       = 1'b0;
    perr_o       = 1'b0;
`ifdef VMICRO16_UART_RX_PARITY_EN
    perr_flag_d  = perr_flag_q;
`endif
    case (state_q)
      UART_ST_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s) begin
          state_d = UART_ST_START;
          bit_d   = '0;
`ifdef VMICRO16_UART_RX_PARITY_EN
          perr_flag_d = 1'b0;
`endif
        end
      end
      UART_ST_START: begin
        if (tick_half) begin
          cnt_d   = '0;
          state_d = rx_s ? UART_ST_IDLE : UART_ST_DATA;
        end
      end
      UART_ST_DATA: begin
        if (tick_full) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef VMICRO16_UART_RX_PARITY_EN
            state_d = UART_ST_PARITY;
`else
            state_d = UART_ST_STOP;
`endif
          end
        end
      end
`ifdef VMICRO16_UART_RX_PARITY_EN
      UART_ST_PARITY: begin
        if (tick_full) begin
          cnt_d       = '0;
          perr_flag_d = (rx_s != even_parity(shift_q));
          perr_o      = perr_flag_d;
          state_d     = UART_ST_STOP;
        end
      end
`endif
      UART_ST_STOP: begin
        if (tick_full) begin
          cnt_d        = '0;
          state_d      = UART_ST_IDLE;
          byte_valid_o = rx_s && !perr_hold;
          ferr_o       = !rx_s;
        end
      end
      default: begin
        state_d = UART_ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      state_q   <= UART_ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
`ifdef VMICRO16_UART_RX_PARITY_EN
      perr_flag_q <= 1'b0;
`endif
    end else begin
      sync_q    <= {sync_q[0], rx_i};
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
`ifdef VMICRO16_UART_RX_PARITY_EN
      perr_flag_q <= perr_flag_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: rtl/vmicro16_uart_rx_apb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vmicro16_uart_rx_apb : APB UART receiver with rx FIFO and sticky flags
// Optional even parity: VMICRO16_UART_RX_PARITY_EN.   Revision 1.0
// ---------------------------------------------------------------------------
module vmicro16_uart_rx_apb
  import vmicro16_uart_rx_apb_pkg::*;
#(
  parameter int BUS_WIDTH    = 16,
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] S_PADDR,
  input  logic                 S_PWRITE,
  input  logic                 S_PSELx,
  input  logic                 S_PENABLE,
  input  logic [BUS_WIDTH-1:0] S_PWDATA,
  output logic [BUS_WIDTH-1:0] S_PRDATA,
  output logic                 S_PREADY,
  input  logic                 uart_rx,
  output logic                 rx_irq
);

  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr, rx_perr;

  vmicro16_uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_core (
    .clk          (clk),
    .reset        (reset),
    .rx_i         (uart_rx),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .ferr_o       (rx_ferr),
    .perr_o       (rx_perr)
  );

  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  uart_flags_t    flags_q, flags_d, flags_set, flags_clr;
  logic           access, rd_access, wr_access, fifo_empty, fifo_full;
  logic           pop, push, ovr_set;
  logic [BUS_WIDTH-1:0] status;
  logic           unused_bus_bits;

  assign unused_bus_bits = ^{S_PADDR[BUS_WIDTH-1:1], S_PWDATA[BUS_WIDTH-1:4], S_PWDATA[0]};

  assign access     = S_PSELx & S_PENABLE;
  assign rd_access  = access & ~S_PWRITE;
  assign wr_access  = access & S_PWRITE;
  assign S_PREADY   = access;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign rx_irq     = ~fifo_empty;

  // Pop is ordered before push, so a full FIFO still accepts a byte on a read cycle.
  assign pop     = rd_access & (S_PADDR[0] == UART_REG_DATA) & ~fifo_empty;
  assign push    = rx_valid & (~fifo_full | pop);
  assign ovr_set = rx_valid & fifo_full & ~pop;

  assign flags_set = '{perr: rx_perr, ovr: ovr_set, ferr: rx_ferr};
  assign flags_clr = (wr_access && S_PADDR[0] == UART_REG_STATUS)
                   ? uart_flags_t'({S_PWDATA[UART_STAT_PERR], S_PWDATA[UART_STAT_OVR],
                                    S_PWDATA[UART_STAT_FERR]})
                   : uart_flags_t'(3'b000);
  assign flags_d   = flags_set | (flags_q & ~flags_clr);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    status = '0;
    status[UART_STAT_COUNT_LSB +: CW] = count_q;
    status[UART_STAT_PERR]            = flags_q.perr;
    status[UART_STAT_OVR]             = flags_q.ovr;
    status[UART_STAT_FERR]            = flags_q.ferr;
    status[UART_STAT_NOT_EMPTY]       = ~fifo_empty;
  end

  // Zero outside a selected read so the interconnect can OR slave outputs.
  always_comb begin
    S_PRDATA = '0;
    if (rd_access) begin
      if (S_PADDR[0] == UART_REG_DATA) begin
        if (!fifo_empty) S_PRDATA[7:0] = mem_q[rd_ptr_q];
      end else begin
        S_PRDATA = status;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_byte;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flags_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
    end
  end

endmodule
`default_nettype wire
